// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types for the cache/memory arbiter: FSM state encoding, grant
// identifiers, default widths and the grant-selection rule.
package cache_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_LINE_W  = 64;
  localparam int DEF_MEM_LAT = 4;

  // With both caches requesting: fixed D priority, or hand the port to
  // whichever side did not win last time.
  function automatic grant_t pick_grant(input logic   i_req,
                                        input logic   d_req,
                                        input logic   prio_d,
                                        input grant_t last_grant);
    grant_t g;
    if (i_req && d_req) begin
      if (prio_d) g = GRANT_D;
      else        g = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
    end else if (d_req) begin
      g = GRANT_D;
    end else begin
      g = GRANT_I;
    end
    return g;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_lat_counter.sv
// Fixed memory-latency counter: a start pulse arms it, then it counts
// 0..MEM_LAT-1 and flags done combinationally on the final held cycle.
module cache_mem_arbiter_lat_counter #(
  parameter int MEM_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  logic             running;
  logic [CNT_W-1:0] cnt;

  assign done = running && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
    end else if (done) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (running) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single main-memory port between I-cache fills and D-cache
// fills/writebacks, one line transaction at a time, with a 1-cycle ack.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int PRIO_D  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  // Handshake: a cache raises x_req and holds it (with its operands) until
  // x_ack pulses for one cycle; it must drop x_req in that ack cycle, since a
  // req still high in the following IDLE cycle is taken as a new request.

  arb_state_t state;
  grant_t     last_grant;
  grant_t     next_grant;
  logic       any_req;
  logic       lat_start;
  logic       lat_done;

  assign any_req    = i_req || d_req;
  assign next_grant = pick_grant(i_req, d_req, PRIO_D != 0, last_grant);
  assign lat_start  = (state == IDLE) && any_req;
  assign busy       = (state != IDLE);

  cache_mem_arbiter_lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat (
    .clk   (clk),
    .rst   (rst),
    .start (lat_start),
    .done  (lat_done)
  );

  // The mem_* command registers double as the latched request operands, so
  // cache inputs changing mid-transaction cannot reach the memory port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          if (any_req) begin
            last_grant <= next_grant;
            if (next_grant == GRANT_D) begin
              state     <= BUSY_D;
              mem_re    <= !d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_we ? d_wdata : '0;
            end else begin
              state     <= BUSY_I;
              mem_re    <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= i_addr;
              mem_wdata <= '0;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (lat_done) begin
            state     <= DONE;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (state == BUSY_I) begin
              i_rdata <= mem_rdata;
              i_ack   <= 1'b1;
            end else begin
              // Writebacks leave the last fill data visible on d_rdata.
              if (!mem_we) d_rdata <= mem_rdata;
              d_ack <= 1'b1;
            end
          end
        end
        DONE: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: drivers push expected acks and memory
// commands into queues; a negedge monitor pops and compares them.
module tb_cache_mem_arbiter;

  localparam int AW = 16;
  localparam int LW = 64;
  localparam int LAT = 4;
  localparam int EW = 1 + 32 + LW;        // {is_d, ack cycle, rdata}
  localparam int CW = 1 + 1 + AW + LW;    // {re, we, addr, wdata}

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          i_ack, d_ack, mem_re, mem_we, busy;
  logic [AW-1:0] mem_addr;

  logic          i_req0 = 1'b0, d_req0 = 1'b0;
  logic [LW-1:0] i_rdata0, d_rdata0, mem_wdata0, mem_rdata0;
  logic          i_ack0, d_ack0, mem_re0, mem_we0, busy0;
  logic [AW-1:0] mem_addr0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp0_q[$];
  logic [CW-1:0] cmd_q[$];

  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic [2:0] hc;

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(LAT), .PRIO_D(1)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  cache_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .MEM_LAT(LAT), .PRIO_D(0)) dut0 (
    .clk(clk), .rst(rst),
    .i_req(i_req0), .i_addr(i_addr), .i_rdata(i_rdata0), .i_ack(i_ack0),
    .d_req(d_req0), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata0), .d_ack(d_ack0),
    .mem_re(mem_re0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0), .busy(busy0)
  );

  function automatic logic [LW-1:0] f(input logic [AW-1:0] a);
    return {a, ~a, a ^ 16'hA5A5, a + 16'h1234};
  endfunction

  // Memory model: read data is only valid on the 4th held read cycle.
  always @(posedge clk or posedge rst) begin
    if (rst)          hc <= '0;
    else if (mem_re)  hc <= hc + 3'd1;
    else              hc <= '0;
  end
  assign mem_rdata  = (mem_re && hc == 3'd3) ? f(mem_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
  assign mem_rdata0 = mem_re0 ? f(mem_addr0) : '0;

  function automatic void chk(input string name, input logic [127:0] got,
                              input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i_drive(input logic [AW-1:0] a);
    bit ok = 0;
    i_req = 1'b1;
    i_addr = a;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (i_ack) ok = 1;
    end
    i_req = 1'b0;
    chk("i_ack_seen", 128'(ok), 128'(1));
  endtask

  task automatic d_drive(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] wd);
    bit ok = 0;
    d_req = 1'b1;
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (d_ack) ok = 1;
    end
    d_req = 1'b0;
    chk("d_ack_seen", 128'(ok), 128'(1));
  endtask

  function automatic void exp_ack(input logic is_d, input int c, input logic [LW-1:0] data);
    exp_q.push_back({is_d, 32'(c), data});
  endfunction

  function automatic void exp_cmd(input logic re, input logic we, input logic [AW-1:0] a,
                                  input logic [LW-1:0] wd);
    cmd_q.push_back({re, we, a, wd});
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    logic [CW-1:0] cur;
    bit in_cmd = 0;
    int run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_cmd = 0;
      end else begin
        chk("re_we_exclusive", 128'(mem_re && mem_we), 128'(0));
        chk("ack_exclusive", 128'(i_ack && d_ack), 128'(0));
        if (i_ack || d_ack) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", 128'({i_ack, d_ack}), 128'(0));
          end else begin
            e = exp_q.pop_front();
            chk("ack_port", 128'(d_ack), 128'(e[EW-1]));
            chk("ack_cycle", 128'(cyc), 128'(e[EW-2 -: 32]));
            chk(d_ack ? "d_rdata" : "i_rdata", 128'(d_ack ? d_rdata : i_rdata), 128'(e[LW-1:0]));
          end
        end
        if (mem_re || mem_we) begin
          if (!in_cmd) begin
            in_cmd = 1;
            run = 1;
            if (cmd_q.size() == 0) begin
              cur = '0;
              chk("unexpected_cmd", 128'({mem_re, mem_we}), 128'(0));
            end else begin
              cur = cmd_q.pop_front();
            end
          end else begin
            run++;
          end
          chk("mem_cmd", 128'({mem_re, mem_we, mem_addr, mem_wdata}), 128'(cur));
        end else if (in_cmd) begin
          in_cmd = 0;
          chk("cmd_length", 128'(run), 128'(LAT));
        end
        if (i_ack0 || d_ack0) begin
          if (exp0_q.size() == 0) begin
            chk("unexpected_ack0", 128'({i_ack0, d_ack0}), 128'(0));
          end else begin
            e = exp0_q.pop_front();
            chk("alt_grant_port", 128'(d_ack0), 128'(e[EW-1]));
            chk("alt_ack_cycle", 128'(cyc), 128'(e[EW-2 -: 32]));
            chk("alt_rdata", 128'(d_ack0 ? d_rdata0 : i_rdata0), 128'(e[LW-1:0]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    int acks;

    // Reset values.
    tick(2);
    chk("rst_ctrl", 128'({i_ack, d_ack, mem_re, mem_we, busy}), 128'(0));
    chk("rst_data", 128'({i_rdata, d_rdata}), 128'(0));
    chk("rst_mem", 128'({mem_addr, mem_wdata}), 128'(0));
    rst = 1'b0;
    tick(2);

    // 1: I fill alone.
    c = cyc;
    exp_ack(1'b0, c + 5, f(16'h0040));
    exp_cmd(1'b1, 1'b0, 16'h0040, '0);
    i_drive(16'h0040);

    // 2: simultaneous I and D fill, D has priority.
    tick(1);
    c = cyc;
    exp_ack(1'b1, c + 5, f(16'h0080));
    exp_cmd(1'b1, 1'b0, 16'h0080, '0);
    exp_ack(1'b0, c + 11, f(16'h0100));
    exp_cmd(1'b1, 1'b0, 16'h0100, '0);
    fork
      i_drive(16'h0100);
      d_drive(1'b0, 16'h0080, '0);
    join

    // 3: D writeback leaves d_rdata at the previous fill.
    tick(1);
    c = cyc;
    exp_ack(1'b1, c + 5, f(16'h0080));
    exp_cmd(1'b0, 1'b1, 16'h0200, 64'hDEAD_BEEF_0123_4567);
    d_drive(1'b1, 16'h0200, 64'hDEAD_BEEF_0123_4567);

    // 6: operands change mid-transaction.
    tick(1);
    c = cyc;
    exp_ack(1'b1, c + 5, f(16'h0010));
    exp_cmd(1'b1, 1'b0, 16'h0010, '0);
    fork
      d_drive(1'b0, 16'h0010, '0);
      begin
        tick(2);
        d_addr = 16'h0020;
        d_we = 1'b1;
        d_wdata = 64'h1111_2222_3333_4444;
      end
    join
    d_we = 1'b0;

    // 4: alternating grants with both requests held.
    tick(1);
    i_addr = 16'h0300;
    d_addr = 16'h0340;
    c = cyc;
    exp0_q.push_back({1'b0, 32'(c + 5), f(16'h0300)});
    exp0_q.push_back({1'b1, 32'(c + 11), f(16'h0340)});
    exp0_q.push_back({1'b0, 32'(c + 17), f(16'h0300)});
    exp0_q.push_back({1'b1, 32'(c + 23), f(16'h0340)});
    i_req0 = 1'b1;
    d_req0 = 1'b1;
    acks = 0;
    for (int k = 0; k < 60 && acks < 4; k++) begin
      @(negedge clk);
      if (i_ack0 || d_ack0) acks++;
    end
    i_req0 = 1'b0;
    d_req0 = 1'b0;
    chk("alt_ack_count", 128'(acks), 128'(4));

    // 5: reset in the middle of a D fill.
    tick(1);
    exp_cmd(1'b1, 1'b0, 16'h0A80, '0);
    d_we = 1'b0;
    d_addr = 16'h0A80;
    d_req = 1'b1;
    tick(3);
    #1;
    chk("pre_rst_busy", 128'({mem_re, busy}), 128'(2'b11));
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", 128'({i_ack, d_ack, mem_re, mem_we, busy}), 128'(0));
    chk("mid_rst_data", 128'({i_rdata, d_rdata}), 128'(0));
    chk("mid_rst_mem", 128'({mem_addr, mem_wdata}), 128'(0));
    d_req = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(10);
    chk("post_rst_idle", 128'(busy), 128'(0));

    // Recovery after reset.
    c = cyc;
    exp_ack(1'b0, c + 5, f(16'h03C0));
    exp_cmd(1'b1, 1'b0, 16'h03C0, '0);
    i_drive(16'h03C0);

    tick(4);
    chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
    chk("cmd_q_drained", 128'(cmd_q.size()), 128'(0));
    chk("exp0_q_drained", 128'(exp0_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
